// File: rtl/lfsr_word_arb_pkg.sv
// Shared types and helpers for the LFSR word arbiter.
package lfsr_word_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } lfsr_arb_state_t;

  // Number of LFSR beats needed to assemble one word.
  function automatic int lfsr_arb_beats(input int word_width, input int bits);
    return (bits > 0) ? (word_width / bits) : 0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at
// or above ptr, wrapping to the lowest requesting index overall.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] gnt_hi;
  logic [N-1:0] gnt_lo;

  // Thermometer mask selecting indices at or above the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign mask_hi[gi] = (PTR_W'(gi) >= ptr);
    end
  endgenerate

  // Isolate the lowest set bit of the masked and unmasked request vectors.
  assign req_hi = req & mask_hi;
  assign gnt_hi = req_hi & (-req_hi);
  assign gnt_lo = req & (-req);
  assign gnt    = (|req_hi) ? gnt_hi : gnt_lo;

endmodule

// File: rtl/lfsr_word_arbiter.sv
// Shares one LFSR among NUM_REQ requesters: round-robin accept, gate the LFSR
// enable, shift beats into a word (oldest beat in the MSBs) and return it on
// a one-hot valid/ready response.
// Optional build macro LFSR_WORD_ARB_PREFETCH_EN: keep the accumulator filling
// in the background while idle so a request can be answered one cycle later.
module lfsr_word_arbiter
  import lfsr_word_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WORD_WIDTH     = 8,
  parameter int BITS_PER_CLOCK = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [WORD_WIDTH-1:0]     rsp_data,
  output logic                      busy,
  output logic                      lfsr_enable,
  input  logic [BITS_PER_CLOCK-1:0] lfsr_bits,
  input  logic                      lfsr_valid
);

  localparam int BEATS = lfsr_arb_beats(WORD_WIDTH, BITS_PER_CLOCK);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BEATS + 1);

  generate
    if (BITS_PER_CLOCK < 1 || BITS_PER_CLOCK > 8) begin : g_bad_bits
      $error("BITS_PER_CLOCK must be within 1..8");
    end
    if (WORD_WIDTH % BITS_PER_CLOCK != 0) begin : g_bad_ratio
      $error("BITS_PER_CLOCK must divide WORD_WIDTH");
    end
    if (NUM_REQ < 2) begin : g_bad_num
      $error("NUM_REQ must be at least 2");
    end
  endgenerate

  lfsr_arb_state_t         state_reg, state_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [PTR_W-1:0]        grant_reg, grant_next;
  logic [WORD_WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]        count_reg, count_next;

  logic [NUM_REQ-1:0]      gnt;
  logic [PTR_W-1:0]        gnt_idx;
  logic [WORD_WIDTH-1:0]   acc_shift;
  logic                    count_full;
  logic                    fill_en;
  logic                    beat;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_reg),
    .gnt (gnt)
  );

  // Encode the one-hot grant into the index that is latched on accept.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  // New beat enters at the LSB end so the oldest beat ends up in the MSBs.
  generate
    if (BITS_PER_CLOCK == WORD_WIDTH) begin : g_shift_whole
      assign acc_shift = lfsr_bits;
    end else begin : g_shift_part
      assign acc_shift = {acc_reg[WORD_WIDTH-BITS_PER_CLOCK-1:0], lfsr_bits};
    end
  endgenerate

  assign count_full = (count_reg == CNT_W'(BEATS));

  // LFSR enable: only while a word is still being assembled.
  always_comb begin
    fill_en = 1'b0;
    case (state_reg)
`ifdef LFSR_WORD_ARB_PREFETCH_EN
      IDLE:    fill_en = !count_full;
`endif
      FILL:    fill_en = !count_full;
      default: fill_en = 1'b0;
    endcase
  end

  // No accepts and no LFSR advance while reset is being applied.
  assign lfsr_enable = fill_en & reset_n;
  assign beat        = lfsr_enable & lfsr_valid;
  assign req_ready   = (state_reg == IDLE && reset_n) ? gnt : '0;
  assign busy        = (state_reg != IDLE);
  assign rsp_data    = (state_reg == RESP) ? acc_reg : '0;

  // One-hot response valid toward the latched grant.
  always_comb begin
    rsp_valid = '0;
    if (state_reg == RESP) rsp_valid[grant_reg] = 1'b1;
  end

  // Next-state: accumulate beats, accept in IDLE, finish word, handshake.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    acc_next   = acc_reg;
    count_next = count_reg;

    if (beat) begin
      acc_next   = acc_shift;
      count_next = count_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (|gnt) begin
          grant_next = gnt_idx;
          ptr_next   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          // A prefetched full word skips FILL; otherwise fill from current count.
          state_next = (count_next == CNT_W'(BEATS)) ? RESP : FILL;
        end
      end
      FILL: begin
        if (count_next == CNT_W'(BEATS)) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_reg]) begin
          acc_next   = '0;
          count_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Self-checking bench for lfsr_word_arbiter: stimulus pushes expected
// responses into a scoreboard queue, a negedge monitor pops and compares.
module tb_lfsr_word_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] rsp_valid;
  logic [3:0] rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic       lfsr_enable;
  logic [0:0] lfsr_bits;
  logic       lfsr_valid;

  typedef struct {
    logic [3:0] onehot;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   bcnt    = 0;
  bit   const_one = 1'b0;
  bit   rsp_seen  = 1'b0;
  int   t0;
  int   order [5] = '{0, 1, 2, 3, 0};

  lfsr_word_arbiter #(
    .NUM_REQ        (4),
    .WORD_WIDTH     (8),
    .BITS_PER_CLOCK (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .lfsr_enable (lfsr_enable),
    .lfsr_bits   (lfsr_bits),
    .lfsr_valid  (lfsr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LFSR stub: alternating 1,0,1,... per accepted beat, or constant 1.
  always @(posedge clk) begin
    if (!reset_n) bcnt <= 0;
    else if (lfsr_enable && lfsr_valid) bcnt <= bcnt + 1;
  end
  assign lfsr_bits = const_one ? 1'b1 : ~bcnt[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [3:0] oh, input logic [7:0] d, input int c);
    exp_t e;
    e.onehot = oh;
    e.data   = d;
    e.cyc    = c;
    sb.push_back(e);
  endtask

  task automatic timeout_fail(input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout after 40 cycles, required event never seen", what);
  endtask

  task automatic wait_rsp(input string what);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0000) return;
    end
    timeout_fail(what);
  endtask

  task automatic wait_grant(input string what);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) return;
    end
    timeout_fail(what);
  endtask

  task automatic wait_idle(input string what);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    timeout_fail(what);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req_valid  = 4'b0000;
    rsp_ready  = 4'b0000;
    lfsr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: on each new response compare against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid == 4'b0000) begin
      rsp_seen = 1'b0;
    end else if (!rsp_seen) begin
      rsp_seen = 1'b1;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b, required no response", rsp_valid);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_onehot", 32'(rsp_valid), 32'(mon_e.onehot));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));

`ifdef LFSR_WORD_ARB_PREFETCH_EN
    // Background fill right after reset, then 12 idle cycles.
    check("pf_enable_start", 32'(lfsr_enable), 32'(1));
    repeat (12) @(negedge clk);
    check("pf_enable_full", 32'(lfsr_enable), 32'(0));
    check("pf_idle_busy", 32'(busy), 32'(0));
    req_valid = 4'b0001;
    t0 = cyc;
    #1;
    check("pf_req_ready", 32'(req_ready), 32'(4'b0001));
    push_exp(4'b0001, 8'hAA, t0 + 1);
    @(negedge clk);
    req_valid = 4'b0000;
    check("pf_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    check("pf_rsp_clear", 32'(rsp_valid), 32'(0));
    check("pf_refill", 32'(lfsr_enable), 32'(1));
`else
    repeat (3) @(negedge clk);
    check("idle_enable", 32'(lfsr_enable), 32'(0));

    // 1: single pulsed request, alternating bits -> AA at T+9.
    req_valid = 4'b0100;
    t0 = cyc;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'(4'b0100));
    push_exp(4'b0100, 8'hAA, t0 + 9);
    @(negedge clk);
    req_valid = 4'b0000;
    check("t1_busy", 32'(busy), 32'(1));
    check("t1_enable", 32'(lfsr_enable), 32'(1));
    check("t1_no_ready", 32'(req_ready), 32'(0));
    wait_rsp("t1_rsp");
    check("t1_enable_resp", 32'(lfsr_enable), 32'(0));
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = 4'b0000;
    check("t1_rsp_clear", 32'(rsp_valid), 32'(0));
    check("t1_idle", 32'(busy), 32'(0));

    // 2: all requesting, rsp_ready tied high -> grants 0,1,2,3,0.
    do_reset();
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2_grant_wait");
      t0 = cyc;
      check("t2_grant", 32'(req_ready), 32'(1) << order[k]);
      check("t2_grant_idle", 32'(busy), 32'(0));
      push_exp(4'(1 << order[k]), 8'hAA, t0 + 9);
      @(negedge clk);
      if (k == 4) req_valid = 4'b0000;
      check("t2_no_grant_busy", 32'(req_ready), 32'(0));
      check("t2_busy", 32'(busy), 32'(1));
    end
    wait_idle("t2_idle");
    rsp_ready = 4'b0000;

    // 3: lfsr_valid low for 3 FILL cycles, bits=1 -> FF at T+12.
    const_one = 1'b1;
    req_valid = 4'b0001;
    t0 = cyc;
    #1;
    check("t3_req_ready", 32'(req_ready), 32'(4'b0001));
    push_exp(4'b0001, 8'hFF, t0 + 12);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 4'b0000;
      lfsr_valid = !(c == 3 || c == 5 || c == 6);
      if (c == 3) check("t3_enable_stall", 32'(lfsr_enable), 32'(1));
    end
    lfsr_valid = 1'b1;
    rsp_ready  = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    check("t3_rsp_clear", 32'(rsp_valid), 32'(0));
    const_one = 1'b0;

    // 4: response held 5 cycles, non-granted rsp_ready lines high.
    req_valid = 4'b1000;
    t0 = cyc;
    #1;
    check("t4_req_ready", 32'(req_ready), 32'(4'b1000));
    push_exp(4'b1000, 8'hAA, t0 + 9);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp("t4_rsp");
    rsp_ready = 4'b0111;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid), 32'(4'b1000));
      check("t4_hold_data", 32'(rsp_data), 32'(8'hAA));
      check("t4_hold_enable", 32'(lfsr_enable), 32'(0));
    end
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = 4'b0000;
    check("t4_rsp_clear", 32'(rsp_valid), 32'(0));

    // 5: reset mid-FILL aborts; next request yields a full 8-beat word.
    req_valid = 4'b0010;
    #1;
    check("t5_req_ready", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    check("t5_busy_fill", 32'(busy), 32'(1));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("t5_rst_req_ready", 32'(req_ready), 32'(0));
    check("t5_rst_enable", 32'(lfsr_enable), 32'(0));
    check("t5_rst_data", 32'(rsp_data), 32'(0));
    @(negedge clk);
    req_valid = 4'b0010;
    t0 = cyc;
    #1;
    check("t5_req_ready2", 32'(req_ready), 32'(4'b0010));
    push_exp(4'b0010, 8'hAA, t0 + 9);
    @(negedge clk);
    req_valid = 4'b0000;
    wait_rsp("t5_rsp");
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = 4'b0000;
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
